sha256_msg_loader: RTL and testbench

Host-side front end for the single-block SHA-256 engine. It accepts a byte stream, packs it big-endian into 32-bit words, and writes those words into the shared word memory. It then appends the SHA-256 padding and bit length, pulses the engine's start, and waits for its done. Finally it reads the 8 digest words back from memory and streams them out over a valid/ready port.

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_byte_packer.sv | 65 ++++++
 rtl/sha256_msg_loader.sv | 178 +++++++++++++++++
 tb/tb_sha256_msg_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message loader.
// Loader FSM encoding and block geometry.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PAD,
    START,
    WAIT,
    RD_REQ,
    RD_WAIT,
    OUT
  } state_t;

  localparam logic [7:0] SHA_PAD_BYTE = 8'h80;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int DIGEST_WORDS = 8;

endpackage

// File: rtl/sha256_byte_packer.sv
// Byte-to-word shift register with lane counter.
// Also forms the padding words for the tail of the block.
module sha256_byte_packer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  in_byte,
  input  logic [5:0]  byte_count,
  input  logic [3:0]  pad_idx,
  output logic        word_done,
  output logic [31:0] full_word,
  output logic [31:0] pad_word
);

  logic [23:0] pack;
  logic [1:0]  lane;
  logic [31:0] part_word;
  logic        is_last;
  logic        is_part;

  // Shift bytes in big-endian; lane counts bytes held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack <= '0;
      lane <= '0;
    end else if (clear) begin
      pack <= '0;
      lane <= '0;
    end else if (push) begin
      pack <= {pack[15:0], in_byte};
      lane <= lane + 2'd1;
    end
  end

  assign word_done = push && (lane == 2'd3);
  assign full_word = {pack, in_byte};

  // Partial word: held bytes, then the pad marker, then zeros.
  always_comb begin
    part_word = '0;
    unique case (lane)
      2'd0: part_word = {SHA_PAD_BYTE, 24'h0};
      2'd1: part_word = {pack[7:0], SHA_PAD_BYTE, 16'h0};
      2'd2: part_word = {pack[15:0], SHA_PAD_BYTE, 8'h0};
      2'd3: part_word = {pack[23:0], SHA_PAD_BYTE};
    endcase
  end

  assign is_last = (pad_idx == 4'(WORDS_PER_BLOCK - 1));
  assign is_part = (pad_idx == byte_count[5:2]);

  // Select length word, partial word or zero fill.
  always_comb begin
    pad_word = '0;
    unique case (1'b1)
      is_last: pad_word = {23'h0, byte_count, 3'b000};
      is_part: pad_word = part_word;
      default: pad_word = '0;
    endcase
  end

endmodule

// File: rtl/sha256_msg_loader.sv
// Host front end for the single-block SHA-256 engine.
// Loads and pads the message, runs the engine, streams digest.
module sha256_msg_loader
  import sha256_pkg::*;
#(
  parameter logic [15:0] MSG_ADDR  = 16'h0000,
  parameter logic [15:0] OUT_ADDR  = 16'h0010,
  parameter int          MAX_BYTES = 55
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  output logic        mem_grant_eng,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        dig_valid,
  output logic [31:0] dig_data,
  input  logic        dig_ready,
  output logic        err_overflow
);

  localparam logic [5:0] MAXC = 6'(MAX_BYTES);

  state_t      state;
  state_t      next;
  logic [5:0]  cnt;
  logic [5:0]  cnt_inc;
  logic        wr_pend;
  logic [3:0]  wr_idx;
  logic [31:0] wr_word;
  logic [3:0]  pad_idx;
  logic [2:0]  rd_idx;
  logic        done_q;
  logic        accept;
  logic        room;
  logic        push;
  logic        drop;
  logic        clear;
  logic        done_rise;
  logic        pad_last;
  logic        word_done;
  logic [31:0] full_word;
  logic [31:0] pad_word;

  assign message_addr = MSG_ADDR;
  assign output_addr  = OUT_ADDR;

  assign accept    = in_valid && in_ready;
  assign room      = (cnt < MAXC);
  assign push      = accept && room;
  assign drop      = accept && !room;
  assign cnt_inc   = cnt + 6'd1;
  assign done_rise = sha_done && !done_q;
  assign pad_last  = (pad_idx == 4'(WORDS_PER_BLOCK - 1));
  assign clear     = (state != IDLE) && (next == IDLE);

  sha256_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .push       (push),
    .in_byte    (in_data),
    .byte_count (cnt),
    .pad_idx    (pad_idx),
    .word_done  (word_done),
    .full_word  (full_word),
    .pad_word   (pad_word)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  // Next-state decode.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:
        if (accept) next = in_last ? PAD : COLLECT;
      COLLECT:
        if (accept && in_last)
          next = (err_overflow || drop) ? IDLE : PAD;
      PAD:
        if (!wr_pend && pad_last) next = START;
      START:
        next = WAIT;
      WAIT:
        if (done_rise) next = RD_REQ;
      RD_REQ:
        next = RD_WAIT;
      RD_WAIT:
        next = OUT;
      OUT:
        if (dig_ready)
          next = (rd_idx == 3'(DIGEST_WORDS - 1)) ? IDLE : RD_REQ;
      default:
        next = IDLE;
    endcase
  end

  // Handshake, engine and memory port outputs.
  always_comb begin
    in_ready       = (state == IDLE) || (state == COLLECT);
    sha_start      = (state == START);
    mem_grant_eng  = (state == START) || (state == WAIT);
    dig_valid      = (state == OUT);
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (wr_pend) begin
      mem_we         = 1'b1;
      mem_addr       = MSG_ADDR + {12'h0, wr_idx};
      mem_write_data = wr_word;
    end else if (state == PAD) begin
      mem_we         = 1'b1;
      mem_addr       = MSG_ADDR + {12'h0, pad_idx};
      mem_write_data = pad_word;
    end else if (state == RD_REQ) begin
      mem_addr       = OUT_ADDR + {13'h0, rd_idx};
    end
  end

  // Byte count, overflow flag and deferred word write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      err_overflow <= 1'b0;
      wr_pend      <= 1'b0;
      wr_idx       <= '0;
      wr_word      <= '0;
    end else begin
      if (clear)      cnt <= '0;
      else if (push)  cnt <= cnt_inc;
      else if (drop)  cnt <= MAXC + 6'd1;
      if (state == IDLE && accept) err_overflow <= 1'b0;
      else if (drop)               err_overflow <= 1'b1;
      wr_pend <= word_done;
      if (word_done) begin
        wr_idx  <= cnt[5:2];
        wr_word <= full_word;
      end
    end
  end

  // Pad index, done edge detector, digest read-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_idx  <= '0;
      done_q   <= 1'b0;
      rd_idx   <= '0;
      dig_data <= '0;
    end else begin
      if (in_ready && next == PAD)
        pad_idx <= cnt_inc[5:2];
      else if (state == PAD && !wr_pend)
        pad_idx <= pad_idx + 4'd1;
      done_q <= sha_done;
      if (state == START)
        rd_idx <= '0;
      else if (state == OUT && dig_ready)
        rd_idx <= rd_idx + 3'd1;
      if (state == RD_WAIT)
        dig_data <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Scoreboard bench for sha256_msg_loader.
// Memory and engine models with directed messages.
module tb_sha256_msg_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        sha_start;
  wire         sha_done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        mem_grant_eng;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        dig_valid;
  logic [31:0] dig_data;
  logic        dig_ready = 1'b1;
  logic        err_overflow;

  logic        eng_manual = 1'b0;
  logic        man_done = 1'b0;
  logic        auto_done = 1'b0;
  int          eng_cnt = 0;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int dig_idx = 0;
  int stall_left = 0;

  logic [47:0] exp_wr[$];
  logic [31:0] exp_dig[$];
  logic [7:0]  msg[$];
  logic [31:0] mem[0:63];
  logic [31:0] digest[0:7];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_start = 1'b0;
  logic [31:0] prev_data = '0;

  assign sha_done = eng_manual ? man_done : auto_done;

  always #5 clk = ~clk;

  sha256_msg_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .sha_start      (sha_start),
    .sha_done       (sha_done),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .mem_grant_eng  (mem_grant_eng),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dig_valid      (dig_valid),
    .dig_data       (dig_data),
    .dig_ready      (dig_ready),
    .err_overflow   (err_overflow)
  );

  task automatic chk(input string name, input logic [47:0] got,
                     input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Shared word memory; loader writes only when it owns the port.
  always @(posedge clk) begin
    if (mem_we && !mem_grant_eng) mem[mem_addr[5:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[5:0]];
  end

  // Engine model: done pulse a few cycles after start.
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (eng_cnt == 1) auto_done = 1'b1;
    if (eng_cnt > 0) eng_cnt--;
    if (sha_start && !eng_manual) eng_cnt = 5;
  end

  // Digest consumer, stalls on word 3 when asked.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && dig_valid && (dig_idx % 8) == 3) begin
      dig_ready = 1'b0;
      stall_left--;
    end else begin
      dig_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every write and digest beat.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (exp_wr.size() == 0)
          chk("unexpected_write", {mem_addr, mem_write_data}, 48'hx);
        else
          chk("mem_write", {mem_addr, mem_write_data}, exp_wr.pop_front());
      end
      if (sha_start) begin
        starts++;
        chk("start_one_cycle", 48'(prev_start), 48'h0);
      end
      if (dig_valid) chk("valid_vs_grant", 48'(mem_grant_eng), 48'h0);
      if (prev_valid && !prev_ready)
        chk("dig_hold", {15'h0, dig_valid, dig_data}, {16'h1, prev_data});
      if (dig_valid && dig_ready) begin
        if (exp_dig.size() == 0)
          chk("unexpected_digest", 48'(dig_data), 48'hx);
        else
          chk("digest", 48'(dig_data), 48'(exp_dig.pop_front()));
        dig_idx++;
      end
      prev_valid = dig_valid;
      prev_ready = dig_ready;
      prev_data  = dig_data;
      prev_start = sha_start;
    end
  end

  function automatic logic [31:0] word_of(int w);
    logic [31:0] r;
    int n;
    n = msg.size();
    r = '0;
    if (w == 15) return 32'(n * 8);
    for (int l = 0; l < 4; l++) begin
      int k;
      k = 4 * w + l;
      r = r << 8;
      if (k < n)       r[7:0] = msg[k];
      else if (k == n) r[7:0] = 8'h80;
    end
    return r;
  endfunction

  // Push expected writes (and digest when the run completes), then drive.
  task automatic send(input bit want_digest);
    int n;
    int nw;
    int guard;
    n = msg.size();
    nw = (n > 55) ? 13 : 16;
    for (int w = 0; w < nw; w++) exp_wr.push_back({16'(w), word_of(w)});
    if (want_digest)
      for (int i = 0; i < 8; i++) exp_dig.push_back(digest[i]);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = msg[k];
      in_last  = (k == n - 1);
      guard = 0;
      while (!in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) chk("in_ready_timeout", 48'h0, 48'h1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_wr.size() != 0 || exp_dig.size() != 0 || !in_ready)
           && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("run_timeout", 48'(t >= 3000), 48'h0);
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!sha_start && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("start_timeout", 48'(t >= 500), 48'h0);
  endtask

  task automatic fill(input int n, input logic [7:0] b);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(b);
  endtask

  initial begin
    int s0;
    digest[0] = 32'hba7816bf; digest[1] = 32'h8f01cfea;
    digest[2] = 32'h414140de; digest[3] = 32'h5dae2223;
    digest[4] = 32'hb00361a3; digest[5] = 32'h96177a9c;
    digest[6] = 32'hb410ff61; digest[7] = 32'hf20015ad;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[16 + i] = digest[i];

    repeat (3) @(negedge clk);
    chk("rst_start", 48'(sha_start), 48'h0);
    chk("rst_grant", 48'(mem_grant_eng), 48'h0);
    chk("rst_we", 48'(mem_we), 48'h0);
    chk("rst_valid", 48'(dig_valid), 48'h0);
    chk("rst_ovf", 48'(err_overflow), 48'h0);
    chk("msg_addr", 48'(message_addr), 48'h0000);
    chk("out_addr", 48'(output_addr), 48'h0010);
    reset_n = 1'b1;
    @(negedge clk);

    // "abc": word0 61626380, word15 00000018.
    msg = '{8'h61, 8'h62, 8'h63};
    chk("abc_w0_model", 48'(word_of(0)), 48'h61626380);
    s0 = starts;
    send(1'b1);
    wait_idle();
    chk("abc_starts", 48'(starts - s0), 48'h1);

    // 4-byte word completion with in_last.
    msg = '{8'hde, 8'had, 8'hbe, 8'hef};
    chk("beef_w1_model", 48'(word_of(1)), 48'h80000000);
    send(1'b1);
    wait_idle();

    // Maximum length: word13 AAAAAA80, word15 1B8.
    fill(55, 8'haa);
    chk("max_w13_model", 48'(word_of(13)), 48'haaaaaa80);
    chk("max_w15_model", 48'(word_of(15)), 48'h000001b8);
    send(1'b1);
    wait_idle();
    chk("max_no_ovf", 48'(err_overflow), 48'h0);

    // Overflow: no start, no digest, back to idle.
    fill(56, 8'haa);
    s0 = starts;
    send(1'b0);
    wait_idle();
    repeat (30) @(negedge clk);
    chk("ovf_flag", 48'(err_overflow), 48'h1);
    chk("ovf_no_start", 48'(starts - s0), 48'h0);
    chk("ovf_idle", 48'(in_ready), 48'h1);

    // One-byte message clears the flag.
    msg = '{8'h5a};
    send(1'b1);
    chk("ovf_cleared", 48'(err_overflow), 48'h0);
    wait_idle();

    // Digest back-pressure on word 3.
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    stall_left = 10;
    send(1'b1);
    wait_idle();
    chk("stall_used", 48'(stall_left), 48'h0);

    // Reset while waiting on the engine.
    eng_manual = 1'b1;
    man_done = 1'b0;
    msg = '{8'h78, 8'h79};
    send(1'b0);
    wait_start();
    @(negedge clk);
    chk("wait_grant", 48'(mem_grant_eng), 48'h1);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_grant", 48'(mem_grant_eng), 48'h0);
    chk("abort_start", 48'(sha_start), 48'h0);
    chk("abort_we", 48'(mem_we), 48'h0);
    chk("abort_addr", 48'({mem_addr, mem_write_data}), 48'h0);
    chk("abort_dig", 48'({dig_valid, dig_data}), 48'h0);
    chk("abort_ovf", 48'(err_overflow), 48'h0);
    man_done = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Done stuck high at start must wait for a fresh edge.
    msg = '{8'h61, 8'h62, 8'h63};
    send(1'b1);
    wait_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stuck_grant", 48'({mem_grant_eng, dig_valid}), 48'h2);
    end
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    eng_manual = 1'b0;
    wait_idle();

    chk("wr_queue_empty", 48'(exp_wr.size()), 48'h0);
    chk("dig_queue_empty", 48'(exp_dig.size()), 48'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
